// File: rtl/segment_sequencer.sv
// segment_sequencer: pulls 4-byte motion records from the segment FIFO and plays them out
// as per-axis step/dir signals. Define SEGMENT_UNDERRUN_COUNT_EN to add the underrun counter.
module segment_sequencer #(
   parameter int FIFO_SIZE_WIDTH = 7,
   parameter int MIN_DELAY       = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [FIFO_SIZE_WIDTH-1:0] fifo_size,
   input  logic                       fifo_empty,
   output logic                       fifo_read_en,
   input  logic [7:0]                 fifo_data,
   output logic [3:0]                 step,
   output logic [3:0]                 dir,
   output logic                       busy,
   output logic                       underrun
`ifdef SEGMENT_UNDERRUN_COUNT_EN
   ,output logic [7:0]                underrun_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t      state_q;
   logic        rd_en_q;
   logic [2:0]  cnt_q;
   logic [7:0]  rec_q [4];
   logic [3:0]  dir_q;
   logic [3:0]  mask_q;
   logic [7:0]  remaining_q;
   logic [15:0] timer_q;
   logic        busy_q;
   logic        underrun_q;
`ifdef SEGMENT_UNDERRUN_COUNT_EN
   logic [7:0]  ur_count_q;
`endif

   logic [15:0] delay_raw_d;
   logic [15:0] delay_eff_d;
   logic        have_record_d;
   logic        fire_d;

   // Clamped delay, record availability and the step qualifier for the current cycle.
   always_comb begin
      delay_raw_d   = {rec_q[3], rec_q[2]};
      delay_eff_d   = (delay_raw_d < 16'(MIN_DELAY)) ? 16'(MIN_DELAY) : delay_raw_d;
      have_record_d = (fifo_size >= FIFO_SIZE_WIDTH'(4));
      fire_d        = (state_q == S_RUN) && enable && (remaining_q != 8'd0) && (timer_q == 16'd0);
   end

   // Pop guard keeps a mis-sized FIFO from underflowing; step is qualified by enable in-cycle.
   assign fifo_read_en = rd_en_q & ~fifo_empty;
   assign step         = fire_d ? mask_q : 4'd0;
   assign dir          = dir_q;
   assign busy         = busy_q;
   assign underrun     = underrun_q;
`ifdef SEGMENT_UNDERRUN_COUNT_EN
   assign underrun_count = ur_count_q;
`endif

   // Sequencer FSM: fetch, load, then time out the step pulses of one record.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rd_en_q     <= 1'b0;
         cnt_q       <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            rec_q[i] <= 8'd0;
         end
         dir_q       <= 4'd0;
         mask_q      <= 4'd0;
         remaining_q <= 8'd0;
         timer_q     <= 16'd0;
         busy_q      <= 1'b0;
         underrun_q  <= 1'b0;
`ifdef SEGMENT_UNDERRUN_COUNT_EN
         ur_count_q  <= 8'd0;
`endif
      end else begin
         underrun_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (enable && have_record_d) begin
                  state_q <= S_FETCH;
                  rd_en_q <= 1'b1;
                  cnt_q   <= 3'd0;
                  busy_q  <= 1'b1;
               end
            end
            S_FETCH: begin
               // cnt 0..3 pop; cnt 1..4 capture the byte popped the cycle before.
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd3) begin
                  rd_en_q <= 1'b0;
               end
               if (cnt_q != 3'd0) begin
                  rec_q[cnt_q[1:0] - 2'd1] <= fifo_data;
               end
               if (cnt_q == 3'd4) begin
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               dir_q       <= rec_q[0][3:0];
               mask_q      <= rec_q[0][7:4];
               remaining_q <= rec_q[1];
               timer_q     <= delay_eff_d;
               state_q     <= S_RUN;
            end
            S_RUN: begin
               if (enable) begin
                  if (remaining_q == 8'd0) begin
                     if (have_record_d) begin
                        state_q <= S_FETCH;
                        rd_en_q <= 1'b1;
                        cnt_q   <= 3'd0;
                     end else begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        underrun_q <= 1'b1;
`ifdef SEGMENT_UNDERRUN_COUNT_EN
                        if (ur_count_q != 8'hFF) begin
                           ur_count_q <= ur_count_q + 8'd1;
                        end
`endif
                     end
                  end else if (timer_q == 16'd0) begin
                     remaining_q <= remaining_q - 8'd1;
                     timer_q     <= delay_eff_d;
                  end else begin
                     timer_q <= timer_q - 16'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               rd_en_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer: a byte-FIFO model feeds records and per-cycle
// outputs are logged from the cycle the record becomes visible (cycle 0) onwards.
module tb_segment_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [6:0] fifo_size;
   logic       fifo_empty;
   logic       fifo_read_en;
   logic [7:0] fifo_data = 8'h00;
   logic [3:0] step;
   logic [3:0] dir;
   logic       busy;
   logic       underrun;
`ifdef SEGMENT_UNDERRUN_COUNT_EN
   logic [7:0] underrun_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] fmem [0:4095];
   int         wr_ptr = 0;
   int         rd_ptr = 0;

   logic [3:0] st_log   [0:127];
   logic [3:0] dir_log  [0:127];
   logic       re_log   [0:127];
   logic       busy_log [0:127];
   logic       ur_log   [0:127];
   int         pulse_tab [$];

   segment_sequencer #(.FIFO_SIZE_WIDTH(7), .MIN_DELAY(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .fifo_size    (fifo_size),
      .fifo_empty   (fifo_empty),
      .fifo_read_en (fifo_read_en),
      .fifo_data    (fifo_data),
      .step         (step),
      .dir          (dir),
      .busy         (busy),
      .underrun     (underrun)
`ifdef SEGMENT_UNDERRUN_COUNT_EN
      ,.underrun_count (underrun_count)
`endif
   );

   always #5 clk = ~clk;

   assign fifo_size  = 7'(wr_ptr - rd_ptr);
   assign fifo_empty = (wr_ptr == rd_ptr);

   // FIFO read port: data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      if (fifo_read_en && (wr_ptr != rd_ptr)) begin
         fifo_data <= fmem[rd_ptr[11:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fmem[wr_ptr[11:0]] = b;
      wr_ptr++;
   endtask

   task automatic push_rec(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      push(b0);
      push(b1);
      push(b2);
      push(b3);
   endtask

   // Logs cycles 1..n; enable is low for cycles off_lo..off_hi-1 (no window when both 0).
   task automatic capture(input int n, input int off_lo, input int off_hi);
      for (int t = 1; t <= n; t++) begin
         @(posedge clk);
         #1;
         if (t == off_lo) enable = 1'b0;
         if (t == off_hi) enable = 1'b1;
         @(negedge clk);
         st_log[t]   = step;
         dir_log[t]  = dir;
         re_log[t]   = fifo_read_en;
         busy_log[t] = busy;
         ur_log[t]   = underrun;
      end
   endtask

   function automatic int count_hi(input int sel, input int n);
      int c = 0;
      for (int t = 1; t <= n; t++) begin
         case (sel)
            0:       c += (st_log[t] != 4'd0) ? 1 : 0;
            1:       c += re_log[t] ? 1 : 0;
            2:       c += busy_log[t] ? 1 : 0;
            3:       c += ur_log[t] ? 1 : 0;
            default: c += 0;
         endcase
      end
      return c;
   endfunction

   function automatic logic in_tab(input int t);
      foreach (pulse_tab[i]) begin
         if (pulse_tab[i] == t) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check_train(input string tag, input int n, input logic [3:0] mask);
      for (int t = 1; t <= n; t++) begin
         check_eq($sformatf("%s@%0d", tag, t), 32'(st_log[t]), 32'(in_tab(t) ? mask : 4'h0));
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_step", 32'(step), 32'h0);
      check_eq("rst_dir", 32'(dir), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_underrun", 32'(underrun), 32'h0);
      check_eq("rst_read_en", 32'(fifo_read_en), 32'h0);
      reset = 1'b0;

      // Basic record: mask 1, dir 5, N=3, D=4.
      push_rec(8'h15, 8'd3, 8'h04, 8'h00);
      capture(25, 0, 0);
      check_eq("t1_re1", 32'(re_log[1]), 32'h1);
      check_eq("t1_re4", 32'(re_log[4]), 32'h1);
      check_eq("t1_re5", 32'(re_log[5]), 32'h0);
      check_eq("t1_re_total", 32'(count_hi(1, 25)), 32'd4);
      check_eq("t1_dir6", 32'(dir_log[6]), 32'h0);
      check_eq("t1_dir7", 32'(dir_log[7]), 32'h5);
      pulse_tab = '{11, 16, 21};
      check_train("t1_step", 25, 4'h1);
      check_eq("t1_busy22", 32'(busy_log[22]), 32'h1);
      check_eq("t1_ur23", 32'(ur_log[23]), 32'h1);
      check_eq("t1_busy23", 32'(busy_log[23]), 32'h0);
      check_eq("t1_ur_total", 32'(count_hi(3, 25)), 32'd1);

      // D=0 clamps to 1: mask F, dir A, N=2.
      push_rec(8'hFA, 8'd2, 8'h00, 8'h00);
      capture(14, 0, 0);
      check_eq("t2_dir6", 32'(dir_log[6]), 32'h5);
      check_eq("t2_dir7", 32'(dir_log[7]), 32'hA);
      pulse_tab = '{8, 10};
      check_train("t2_step", 14, 4'hF);
      check_eq("t2_busy11", 32'(busy_log[11]), 32'h1);
      check_eq("t2_ur12", 32'(ur_log[12]), 32'h1);
      check_eq("t2_busy12", 32'(busy_log[12]), 32'h0);

      // Two queued records, N=1 D=2 each.
      push_rec(8'h13, 8'd1, 8'h02, 8'h00);
      push_rec(8'h2C, 8'd1, 8'h02, 8'h00);
      capture(25, 0, 0);
      check_eq("t3_step9", 32'(st_log[9]), 32'h1);
      check_eq("t3_re10", 32'(re_log[10]), 32'h0);
      check_eq("t3_re11", 32'(re_log[11]), 32'h1);
      check_eq("t3_re_total", 32'(count_hi(1, 25)), 32'd8);
      check_eq("t3_dir16", 32'(dir_log[16]), 32'h3);
      check_eq("t3_dir17", 32'(dir_log[17]), 32'hC);
      check_eq("t3_step19", 32'(st_log[19]), 32'h2);
      check_eq("t3_pulses", 32'(count_hi(0, 25)), 32'd2);
      check_eq("t3_ur21", 32'(ur_log[21]), 32'h1);
      check_eq("t3_ur_total", 32'(count_hi(3, 25)), 32'd1);

      // Partial record must not start; the fourth byte releases it.
      push(8'h47);
      push(8'h01);
      push(8'h01);
      capture(6, 0, 0);
      check_eq("t4_no_pop", 32'(count_hi(1, 6)), 32'd0);
      check_eq("t4_no_busy", 32'(count_hi(2, 6)), 32'd0);
      push(8'h00);
      capture(12, 0, 0);
      check_eq("t4_re1", 32'(re_log[1]), 32'h1);
      check_eq("t4_dir7", 32'(dir_log[7]), 32'h7);
      check_eq("t4_step8", 32'(st_log[8]), 32'h4);
      check_eq("t4_pulses", 32'(count_hi(0, 12)), 32'd1);
      check_eq("t4_ur10", 32'(ur_log[10]), 32'h1);

      // N=5 D=10 with enable low for cycles 29..48 (20 cycles) after the 2nd pulse.
      push_rec(8'h81, 8'd5, 8'd10, 8'h00);
      capture(90, 29, 49);
      pulse_tab = '{17, 28, 59, 70, 81};
      check_train("t5_step", 90, 4'h8);
      check_eq("t5_busy82", 32'(busy_log[82]), 32'h1);
      check_eq("t5_ur83", 32'(ur_log[83]), 32'h1);

      // Reset in RUN with remaining=4, one cycle before the next pulse would fire.
      push_rec(8'h3E, 8'd5, 8'd3, 8'h00);
      capture(13, 0, 0);
      check_eq("t6_step10", 32'(st_log[10]), 32'h3);
      check_eq("t6_dir13", 32'(dir_log[13]), 32'hE);
      check_eq("t6_busy13", 32'(busy_log[13]), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_step", 32'(step), 32'h0);
      check_eq("t6_rst_dir", 32'(dir), 32'h0);
      check_eq("t6_rst_busy", 32'(busy), 32'h0);
      check_eq("t6_rst_re", 32'(fifo_read_en), 32'h0);
      reset = 1'b0;

`ifdef SEGMENT_UNDERRUN_COUNT_EN
      check_eq("t7_cnt0", 32'(underrun_count), 32'h0);
      for (int k = 0; k < 300; k++) begin
         logic seen;
         seen = 1'b0;
         push_rec(8'h00, 8'd0, 8'd1, 8'h00);
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (underrun) seen = 1'b1;
         end
         check_eq($sformatf("t7_ur_seen%0d", k), 32'(seen), 32'h1);
         if (k == 0) check_eq("t7_cnt1", 32'(underrun_count), 32'h1);
      end
      check_eq("t7_cnt_sat", 32'(underrun_count), 32'hFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/segment_sequencer.md
# segment_sequencer

Pulls 4-byte motion records from the segment FIFO that the SPI host fills and executes them. For each record it drives per-axis direction levels and emits step pulses at a programmed period. It sits between the FIFO read port and the motor driver pins. It is the sole consumer of the FIFO and keeps it drained in record-sized units.

## Interface

Parameters:
- FIFO_SIZE_WIDTH, 7, width of the FIFO fill-level input (clog2(64)+1)
- MIN_DELAY, 1, lower clamp applied to the record delay field; must be ≥1

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  run permission; low pauses execution
- fifo_size  input  FIFO_SIZE_WIDTH  FIFO fill level in bytes
- fifo_empty  input  1  FIFO empty flag
- fifo_read_en  output  1  FIFO pop strobe, one byte per cycle
- fifo_data  input  8  FIFO read data; valid the cycle after fifo_read_en
- step  output  4  per-axis step pulses, one cycle wide
- dir  output  4  per-axis direction levels
- busy  output  1  high whenever state ≠ IDLE
- underrun  output  1  one-cycle pulse: segment finished with no full record queued
- underrun_count  output  8  saturating underrun counter (only with SEGMENT_UNDERRUN_COUNT_EN)

## Operation

Record format, in FIFO order:
- byte0: [3:0] dir, [7:4] axis mask
- byte1: step count N (0–255)
- byte2: delay D low byte
- byte3: delay D high byte
- Effective delay D' = max(D, MIN_DELAY), 16-bit unsigned.

State machine:
- **IDLE:** go to FETCH when enable=1 and fifo_size≥4. A partial record is never started.
- **FETCH:** assert fifo_read_en for exactly 4 consecutive cycles, gated with !fifo_empty as a guard. Capture fifo_data one cycle after each pop into byte0..3.
- **LOAD:** one cycle. dir←byte0[3:0], mask←byte0[7:4], remaining←N, timer←D'. Go to RUN.
- **RUN:**
  - Cycles with enable=1: if timer=0 and remaining>0, then step=mask for that cycle, remaining−1, timer←D'. Otherwise timer−1 while timer>0.
  - When remaining=0, go to FETCH if fifo_size≥4, else go to IDLE. Pulse underrun when going to IDLE.
- enable=0 in RUN freezes timer and remaining and forces step=0. enable=0 in FETCH/LOAD does not abort; those states complete normally.
- N=0: record consumed, dir updated, no pulses. RUN exits on its first cycle.
- mask=0: timing still executes but step stays 0.
- Concurrent FIFO writes are allowed. fifo_size is sampled only at the IDLE and RUN decision points.

## Timing

- Reset values: state=IDLE, fifo_read_en=0, step=0, dir=0, busy=0, underrun=0, underrun_count=0, all internal registers 0.
- Reset mid-operation returns to IDLE next cycle. Any bytes already popped are discarded.
- Cycle numbering from IDLE seeing fifo_size≥4 at cycle 0:
  - Pops occur at cycles 1–4.
  - Data is captured at cycles 2–5.
  - LOAD is at cycle 6; dir changes at cycle 7.
  - First step at cycle 7+D'.
  - Subsequent steps every D'+1 cycles while enable=1.
- dir is stable at least D' ≥ 1 cycles before the first pulse of a segment. dir never changes in a cycle where step≠0.
- Back-to-back records: the cycle after the last pulse of segment k evaluates remaining=0, and FETCH starts the following cycle. The inter-segment gap is fixed: 7 cycles from the exit decision to LOAD complete.
- underrun asserts for exactly one cycle, on the RUN→IDLE transition.

## Configuration

- SEGMENT_UNDERRUN_COUNT_EN defined:
  - underrun_count increments on each underrun pulse and saturates at 255.
  - It clears only on reset.
- Undefined: the underrun_count port and counter are absent. The underrun pulse is unaffected.

## Test plan

- Reset, then load record {0x15, 3, 0x04, 0x00} → pops at cycles 1–4; dir=0x5 at cycle 7; step=0x1 at cycles 11, 16, 21; then underrun pulse and busy=0.
- Record with D=0, N=2, mask=0xF → D' clamps to 1; step=0xF at cycles 8 and 10.
- Two records queued (8 bytes), N=1, D=2 each → second FETCH begins 2 cycles after the first pulse; exactly one underrun, at the end of record 2.
- Write only 3 bytes → fifo_read_en never asserts and busy stays 0. Writing the 4th byte → fetch starts next cycle.
- N=5, D=10: drop enable for 20 cycles after the 2nd pulse → no pulses while low, timer holds, remaining 3 pulses resume with the original spacing.
- Assert reset during RUN with remaining=4 → step=0, dir=0, state IDLE next cycle. With SEGMENT_UNDERRUN_COUNT_EN, 300 underruns → count reads 255.
